lane_block_sync: RTL and testbench

//  Per-lane 32b->66b RX gearbox with Clause 82 style sync-header block lock.

---
 rtl/lane_block_sync.sv | 143 ++++++++++++++
 tb/tb_lane_block_sync.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_block_sync.sv
// Per-lane 32b->66b RX gearbox with sync-header block lock (hunt by single-bit slip,
// then windowed invalid-header monitoring while locked).
module lane_block_sync #(
   parameter int LOCK_CNT = 64,
   parameter int WIN_CNT  = 64,
   parameter int BAD_CNT  = 16
) (
   input  logic        rx_phy_clk,
   input  logic        rx_resetn,
   input  logic [31:0] rx_data,
   output logic        blk_valid,
   output logic [1:0]  blk_sh,
   output logic [63:0] blk_data,
   output logic        blk_lock,
   output logic        slip_pulse,
   output logic [15:0] bad_sh_cnt
);

   localparam int CW = $clog2(LOCK_CNT + WIN_CNT + BAD_CNT + 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
   localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_CNT - 1);
   localparam logic [CW-1:0] BAD_LAST  = CW'(BAD_CNT - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   logic [127:0]  gbuf_q, gbuf_d;
   logic [6:0]    fill_q, fill_d;
   logic [127:0]  fill_mask, cat;
   logic [6:0]    n;
   logic          emit;
   logic          blk_valid_q;
   logic [1:0]    blk_sh_q;
   logic [63:0]   blk_data_q;
   logic          sh_ok;

   state_t        state_q;
   logic [CW-1:0] good_cnt_q, win_cnt_q, bad_cnt_q;
   logic          blk_lock_q;
   logic          slip_q;
   logic [15:0]   bad_sh_cnt_q;

   // New word lands above the retained bits; a pending slip discards the oldest bit.
   always_comb begin
      fill_mask = (128'd1 << fill_q) - 128'd1;
      cat       = (gbuf_q & fill_mask) | ({96'd0, rx_data} << fill_q);
      n         = fill_q + 7'd32;
      if (slip_q) begin
         cat = cat >> 1;
         n   = n - 7'd1;
      end
      emit = (n >= 7'd66);
      if (emit) begin
         gbuf_d = cat >> 66;
         fill_d = n - 7'd66;
      end else begin
         gbuf_d = cat;
         fill_d = n;
      end
   end

   always_ff @(posedge rx_phy_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         gbuf_q      <= '0;
         fill_q      <= '0;
         blk_valid_q <= 1'b0;
         blk_sh_q    <= '0;
         blk_data_q  <= '0;
      end else begin
         gbuf_q      <= gbuf_d;
         fill_q      <= fill_d;
         blk_valid_q <= emit;
         if (emit) begin
            blk_sh_q   <= cat[1:0];
            blk_data_q <= cat[65:2];
         end
      end
   end

   assign sh_ok = blk_sh_q[0] ^ blk_sh_q[1];

   always_ff @(posedge rx_phy_clk or negedge rx_resetn) begin
      if (!rx_resetn) begin
         state_q      <= HUNT;
         good_cnt_q   <= '0;
         win_cnt_q    <= '0;
         bad_cnt_q    <= '0;
         blk_lock_q   <= 1'b0;
         slip_q       <= 1'b0;
         bad_sh_cnt_q <= '0;
      end else begin
         slip_q <= 1'b0;
         if (blk_valid_q) begin
            case (state_q)
               HUNT: begin
                  if (sh_ok) begin
                     if (good_cnt_q == LOCK_LAST) begin
                        state_q    <= LOCKED;
                        blk_lock_q <= 1'b1;
                        good_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        bad_cnt_q  <= '0;
                     end else begin
                        good_cnt_q <= good_cnt_q + 1'b1;
                     end
                  end else begin
                     slip_q     <= 1'b1;
                     good_cnt_q <= '0;
                  end
               end
               LOCKED: begin
                  if (!sh_ok && bad_sh_cnt_q != 16'hFFFF)
                     bad_sh_cnt_q <= bad_sh_cnt_q + 16'd1;
                  // Losing lock takes priority over a window ending on the same header.
                  if (!sh_ok && bad_cnt_q == BAD_LAST) begin
                     state_q    <= HUNT;
                     blk_lock_q <= 1'b0;
                     slip_q     <= 1'b1;
                     good_cnt_q <= '0;
                     win_cnt_q  <= '0;
                     bad_cnt_q  <= '0;
                  end else if (win_cnt_q == WIN_LAST) begin
                     win_cnt_q <= '0;
                     bad_cnt_q <= '0;
                  end else begin
                     win_cnt_q <= win_cnt_q + 1'b1;
                     if (!sh_ok)
                        bad_cnt_q <= bad_cnt_q + 1'b1;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign blk_valid  = blk_valid_q;
   assign blk_sh     = blk_sh_q;
   assign blk_data   = blk_data_q;
   assign blk_lock   = blk_lock_q;
   assign slip_pulse = slip_q;
   assign bad_sh_cnt = bad_sh_cnt_q;

endmodule

// File: tb/tb_lane_block_sync.sv
// Bench for lane_block_sync: bit-serial 66b block source feeding 32b words, payload
// scoreboard on blk_valid, plus directed lock/slip/error-window/rate/reset checks.
module tb_lane_block_sync;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rx_data = '0;
   logic        blk_valid;
   logic [1:0]  blk_sh;
   logic [63:0] blk_data;
   logic        blk_lock;
   logic        slip_pulse;
   logic [15:0] bad_sh_cnt;

   int checks = 0;
   int errors = 0;

   bit          bq[$];
   logic [65:0] exp_q[$];
   int          gen_idx = 0;
   int          sb_stop = 0;
   bit          inject_en = 1'b0;
   logic [63:0] prbs = 64'h0123_4567_89AB_CDEF;
   int          n_emit = 0;
   int          n_slip = 0;
   int          emit_at_slip = 0;

   always #5 clk = ~clk;

   lane_block_sync dut (
      .rx_phy_clk (clk),
      .rx_resetn  (rst_n),
      .rx_data    (rx_data),
      .blk_valid  (blk_valid),
      .blk_sh     (blk_sh),
      .blk_data   (blk_data),
      .blk_lock   (blk_lock),
      .slip_pulse (slip_pulse),
      .bad_sh_cnt (bad_sh_cnt)
   );

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, lock=%0b emitted=%0d", name, blk_lock, n_emit);
   endtask

   // Header pattern alternates 01/10; injected bad headers are fixed by block index.
   task automatic gen_block();
      logic [1:0]  sh;
      logic [63:0] d;
      prbs = prbs ^ (prbs << 13);
      prbs = prbs ^ (prbs >> 7);
      prbs = prbs ^ (prbs << 17);
      d  = prbs;
      sh = (gen_idx % 2 == 0) ? 2'b01 : 2'b10;
      if (inject_en) begin
         if ((gen_idx >= 70 && gen_idx <= 84) || (gen_idx >= 130 && gen_idx <= 144))
            sh = 2'b00;
         else if (gen_idx >= 448 && gen_idx <= 463)
            sh = 2'b11;
      end
      for (int i = 0; i < 2; i++) bq.push_back(sh[i]);
      for (int i = 0; i < 64; i++) bq.push_back(d[i]);
      if (gen_idx < sb_stop) exp_q.push_back({d, sh});
      gen_idx++;
   endtask

   initial begin : driver
      logic [31:0] w;
      forever begin
         @(negedge clk);
         while (bq.size() < 32) gen_block();
         for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
         rx_data = w;
      end
   end

   initial begin : monitor
      logic [65:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (slip_pulse) begin
               n_slip++;
               emit_at_slip = n_emit;
            end
            if (blk_valid) begin
               n_emit++;
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("sb_block", {blk_data, blk_sh}, e);
               end
            end
         end
      end
   end

   // Called with reset asserted; the first word of the new stream is the first one sampled.
   task automatic start_stream(input int junk, input bit inj, input int stop, input logic [63:0] seed);
      @(posedge clk);
      #1;
      bq.delete();
      exp_q.delete();
      gen_idx      = 0;
      prbs         = seed;
      inject_en    = inj;
      sb_stop      = stop;
      n_emit       = 0;
      n_slip       = 0;
      emit_at_slip = 0;
      for (int i = 0; i < junk; i++) bq.push_back(1'($urandom_range(0, 1)));
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_lock(input logic want, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (blk_lock == want) return;
      end
      timeout_fail(name);
   endtask

   task automatic wait_emit(input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_emit >= target) return;
      end
      timeout_fail(name);
   endtask

   initial begin : main
      int cnt;
      int s0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", 66'({blk_valid, blk_sh, blk_lock, slip_pulse, bad_sh_cnt}), 66'd0);
      check("reset_data", 66'(blk_data), 66'd0);

      // Aligned stream from reset
      start_stream(0, 1'b1, 464, 64'h0123_4567_89AB_CDEF);
      wait_lock(1'b1, 400, "t1_lock");
      check_int("t1_blocks_to_lock", n_emit, 64);
      check_int("t1_slips", n_slip, 0);

      // 15 bad headers in each of two consecutive windows keep lock
      wait_emit(128, 400, "t3_win1");
      check("t3_bad_cnt_w1", 66'(bad_sh_cnt), 66'd15);
      check("t3_lock_w1", 66'(blk_lock), 66'd1);
      wait_emit(192, 400, "t3_win2");
      check("t3_bad_cnt_w2", 66'(bad_sh_cnt), 66'd30);
      check("t3_lock_w2", 66'(blk_lock), 66'd1);

      // 330 cycles carry exactly 160 blocks
      cnt = 0;
      repeat (330) begin
         @(negedge clk);
         #1;
         if (blk_valid) cnt++;
      end
      check_int("t5_rate", cnt, 160);
      check_int("t5_no_slip", n_slip, 0);

      // 16 bad headers in one window drop lock, then 66 slips wrap back
      wait_lock(1'b0, 600, "t4_unlock");
      check_int("t4_unlock_block", n_emit, 464);
      check("t4_slip_with_unlock", 66'(slip_pulse), 66'd1);
      check("t4_bad_cnt", 66'(bad_sh_cnt), 66'd46);
      s0 = n_slip;
      wait_lock(1'b1, 6000, "t4_relock");
      check_int("t4_wrap_slips", n_slip - s0 + 1, 66);
      check_int("t4_relock_clean", n_emit - emit_at_slip, 64);
      check("t4_bad_cnt_hunt", 66'(bad_sh_cnt), 66'd46);
      check_int("sb_drained", exp_q.size(), 0);

      // Asynchronous reset mid-cycle while locked
      repeat (5) @(posedge clk);
      #3;
      check("t6_pre_lock", 66'(blk_lock), 66'd1);
      rst_n = 1'b0;
      #1;
      check("t6_async_ctrl", 66'({blk_valid, blk_sh, blk_lock, slip_pulse, bad_sh_cnt}), 66'd0);
      check("t6_async_data", 66'(blk_data), 66'd0);
      repeat (2) @(posedge clk);

      // Stream offset by 37 bits from a fresh gearbox
      start_stream(37, 1'b0, 0, 64'hFEDC_BA98_7654_3210);
      wait_lock(1'b1, 6000, "t2_lock");
      check_int("t2_slips", n_slip, 37);
      check_int("t2_clean_run", n_emit - emit_at_slip, 64);
      check("t2_bad_cnt", 66'(bad_sh_cnt), 66'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
